// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq: ARM DP sequencer over the combinational alu; owns NZCV.         |
// | Optional ADC/SBC/RSC support when ALU_SEQ_CARRY_OPS_EN is defined. r1.0  |
// +--------------------------------------------------------------------------+
module alu_seq #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_opcode,
   input  logic            req_s,
   input  logic [BITS-1:0] req_a,
   input  logic [BITS-1:0] req_b,
   output logic [BITS-1:0] alu_a,
   output logic [BITS-1:0] alu_b,
   output logic [3:0]      alu_control,
   input  logic [BITS-1:0] alu_c,
   input  logic            alu_ovfl,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [BITS-1:0] rsp_result,
   output logic            rsp_wb,
   output logic [3:0]      flags
);

   localparam int M = BITS - 1;

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                          OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                          OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                          OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

   localparam logic [3:0] ALU_ADDS = 4'b0000, ALU_SUBS = 4'b0001,
                          ALU_ADDU = 4'b0010, ALU_SUBU = 4'b0011,
                          ALU_AND  = 4'b0100, ALU_OR   = 4'b0101,
                          ALU_XOR  = 4'b0110, ALU_NOR  = 4'b0111;

`ifdef ALU_SEQ_CARRY_OPS_EN
   localparam bit CARRY_EN = 1'b1;
`else
   localparam bit CARRY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic            s_q, s_d;
   logic [BITS-1:0] a_q, a_d, b_q, b_d;
   logic            cin_q, cin_d;
   logic [BITS-1:0] t_q, t_d;
   logic            o1_q, o1_d;
   logic [BITS-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]      alu_ctl_q, alu_ctl_d;
   logic [BITS-1:0] result_q, result_d;
   logic            wb_q, wb_d;
   logic [3:0]      flags_q, flags_d;

   // Without the carry feature, carry ops collapse onto their plain siblings.
   function automatic logic [3:0] eff_op(input logic [3:0] op);
`ifdef ALU_SEQ_CARRY_OPS_EN
      return op;
`else
      case (op)
         OP_ADC:  return OP_ADD;
         OP_SBC:  return OP_SUB;
         OP_RSC:  return OP_RSB;
         default: return op;
      endcase
`endif
   endfunction

   function automatic logic is_cmp(input logic [3:0] op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

   function automatic logic is_add(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_CMN);
   endfunction

   function automatic logic is_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_CMP) || (op == OP_RSB);
   endfunction

   function automatic logic is_carry(input logic [3:0] op);
      return CARRY_EN && ((op == OP_ADC) || (op == OP_SBC) || (op == OP_RSC));
   endfunction

   logic [3:0]      w_acc_op;
   logic            w_two_pass;
   logic            w_wr_flags;
   logic [BITS-1:0] w_res;
   logic            w_c, w_v;

   assign w_acc_op   = eff_op(req_opcode);
   assign w_wr_flags = s_q || is_cmp(op_q);
   assign w_two_pass = is_carry(op_q) ||
                       ((is_add(op_q) || is_sub(op_q)) && (s_q || is_cmp(op_q)));

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      s_d       = s_q;
      a_d       = a_q;
      b_d       = b_q;
      cin_d     = cin_q;
      t_d       = t_q;
      o1_d      = o1_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_ctl_d = alu_ctl_q;
      result_d  = result_q;
      wb_d      = wb_q;
      flags_d   = flags_q;
      w_res     = is_carry(op_q) ? alu_c : t_q;
      w_c       = flags_q[1];
      w_v       = flags_q[0];

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = w_acc_op;
               s_d     = req_s;
               a_d     = req_a;
               b_d     = req_b;
               cin_d   = flags_q[1];
               alu_a_d = req_a;
               alu_b_d = req_b;
               case (w_acc_op)
                  OP_AND, OP_TST: alu_ctl_d = ALU_AND;
                  OP_EOR, OP_TEQ: alu_ctl_d = ALU_XOR;
                  OP_ORR:         alu_ctl_d = ALU_OR;
                  OP_BIC: begin
                     alu_ctl_d = ALU_AND;
                     alu_b_d   = ~req_b;
                  end
                  OP_MOV: begin
                     alu_ctl_d = ALU_OR;
                     alu_a_d   = '0;
                  end
                  OP_MVN: begin
                     alu_ctl_d = ALU_NOR;
                     alu_a_d   = req_b;
                  end
                  OP_ADD, OP_CMN: alu_ctl_d = ALU_ADDS;
                  OP_SUB, OP_CMP: alu_ctl_d = ALU_SUBS;
                  OP_RSB: begin
                     alu_ctl_d = ALU_SUBS;
                     alu_a_d   = req_b;
                     alu_b_d   = req_a;
                  end
                  OP_ADC:         alu_ctl_d = ALU_ADDU;
                  OP_SBC:         alu_ctl_d = ALU_SUBU;
                  OP_RSC: begin
                     alu_ctl_d = ALU_SUBU;
                     alu_a_d   = req_b;
                     alu_b_d   = req_a;
                  end
                  default:        alu_ctl_d = ALU_AND;
               endcase
               state_d = PASS1;
            end
         end

         PASS1: begin
            t_d  = alu_c;
            o1_d = alu_ovfl;
            if (w_two_pass) begin
               state_d = PASS2;
               if (is_carry(op_q)) begin
                  // Second carry pass folds the latched carry-in into t.
                  alu_a_d    = alu_c;
                  alu_b_d    = '0;
                  alu_b_d[0] = (op_q == OP_ADC) ? cin_q : ~cin_q;
               end else begin
                  alu_ctl_d = is_add(op_q) ? ALU_ADDU : ALU_SUBU;
               end
            end else begin
               state_d  = RESP;
               result_d = alu_c;
               wb_d     = !is_cmp(op_q);
               if (w_wr_flags)
                  flags_d = {alu_c[M], (alu_c == '0), flags_q[1:0]};
            end
         end

         PASS2: begin
            if (is_add(op_q)) begin
               w_c = alu_ovfl;
               w_v = o1_q;
            end else if (is_sub(op_q)) begin
               w_c = ~alu_ovfl;
               w_v = o1_q;
            end else if (op_q == OP_ADC) begin
               w_c = o1_q | alu_ovfl;
               w_v = (a_q[M] == b_q[M]) && (alu_c[M] != a_q[M]);
            end else if (op_q == OP_SBC) begin
               w_c = ~(o1_q | alu_ovfl);
               w_v = (a_q[M] != b_q[M]) && (alu_c[M] != a_q[M]);
            end else begin
               w_c = ~(o1_q | alu_ovfl);
               w_v = (b_q[M] != a_q[M]) && (alu_c[M] != b_q[M]);
            end
            state_d  = RESP;
            result_d = w_res;
            wb_d     = !is_cmp(op_q);
            if (w_wr_flags)
               flags_d = {w_res[M], (w_res == '0), w_c, w_v};
         end

         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= 4'h0;
         s_q       <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         t_q       <= '0;
         o1_q      <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_ctl_q <= 4'h0;
         result_q  <= '0;
         wb_q      <= 1'b0;
         flags_q   <= 4'h0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         s_q       <= s_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cin_q     <= cin_d;
         t_q       <= t_d;
         o1_q      <= o1_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_ctl_q <= alu_ctl_d;
         result_q  <= result_d;
         wb_q      <= wb_d;
         flags_q   <= flags_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_result  = result_q;
   assign rsp_wb      = wb_q;
   assign flags       = flags_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_ctl_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_seq: directed checks of alu_seq against a behavioural alu. r1.0   |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

   localparam int BITS = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [3:0]      req_opcode = 4'h0;
   logic            req_s = 1'b0;
   logic [BITS-1:0] req_a = '0;
   logic [BITS-1:0] req_b = '0;
   logic [BITS-1:0] alu_a, alu_b, alu_c;
   logic [3:0]      alu_control;
   logic            alu_ovfl;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [BITS-1:0] rsp_result;
   logic            rsp_wb;
   logic [3:0]      flags;

   int checks = 0;
   int failures = 0;

   alu_seq #(.BITS(BITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_s(req_s), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_c(alu_c), .alu_ovfl(alu_ovfl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_wb(rsp_wb), .flags(flags)
   );

   always #5 clk = ~clk;

   // Behavioural alu: signed codes flag overflow, unsigned add flags carry, unsigned sub flags borrow.
   logic [BITS:0] w_wide;
   always_comb begin
      w_wide   = '0;
      alu_c    = '0;
      alu_ovfl = 1'b0;
      case (alu_control)
         4'b0000: begin
            alu_c    = alu_a + alu_b;
            alu_ovfl = (alu_a[BITS-1] == alu_b[BITS-1]) && (alu_c[BITS-1] != alu_a[BITS-1]);
         end
         4'b0001: begin
            alu_c    = alu_a - alu_b;
            alu_ovfl = (alu_a[BITS-1] != alu_b[BITS-1]) && (alu_c[BITS-1] != alu_a[BITS-1]);
         end
         4'b0010: begin
            w_wide   = {1'b0, alu_a} + {1'b0, alu_b};
            alu_c    = w_wide[BITS-1:0];
            alu_ovfl = w_wide[BITS];
         end
         4'b0011: begin
            alu_c    = alu_a - alu_b;
            alu_ovfl = (alu_a < alu_b);
         end
         4'b0100: alu_c = alu_a & alu_b;
         4'b0101: alu_c = alu_a | alu_b;
         4'b0110: alu_c = alu_a ^ alu_b;
         4'b0111: alu_c = ~(alu_a | alu_b);
         default: alu_c = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op starting #1 after an edge; expects the response and a return to idle.
   task automatic do_op(input string tag, input logic [3:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_wb,
                        input logic [3:0] exp_flags, input int exp_lat, input int hold);
      int lat;
      logic [31:0] res0;
      logic [3:0]  flg0;
      if (hold > 0) rsp_ready = 1'b0;
      req_opcode = op;
      req_s      = s;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".latency"}, lat, exp_lat);
      if (!rsp_valid) return;
      check({tag, ".result"}, rsp_result, exp_res);
      check({tag, ".wb"}, {31'b0, rsp_wb}, {31'b0, exp_wb});
      check({tag, ".flags"}, {28'b0, flags}, {28'b0, exp_flags});
      res0 = rsp_result;
      flg0 = flags;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, ".stall_valid"}, {31'b0, rsp_valid}, 32'd1);
         check({tag, ".stall_result"}, rsp_result, res0);
         check({tag, ".stall_flags"}, {28'b0, flags}, {28'b0, flg0});
         check({tag, ".stall_req_ready"}, {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".idle_req_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, ".idle_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      #7;
      check("rst.req_ready", {31'b0, req_ready}, 32'd1);
      check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst.result", rsp_result, 32'd0);
      check("rst.wb", {31'b0, rsp_wb}, 32'd0);
      check("rst.flags", {28'b0, flags}, 32'd0);
      check("rst.alu_a", alu_a, 32'd0);
      check("rst.alu_b", alu_b, 32'd0);
      check("rst.alu_ctl", {28'b0, alu_control}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op("add_ovf", 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 4'b1001, 3, 0);
      do_op("cmp_eq",  4'hA, 1'b0, 32'd5, 32'd5, 32'h0, 1'b0, 4'b0110, 3, 0);
      do_op("sub_ns",  4'h2, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 4'b0110, 2, 0);
      do_op("rsb_s",   4'h3, 1'b1, 32'd5, 32'd3, 32'hFFFF_FFFE, 1'b1, 4'b1000, 3, 0);
      do_op("add_cv",  4'h4, 1'b1, 32'h8000_0000, 32'h8000_0001, 32'h1, 1'b1, 4'b0011, 3, 0);
      do_op("bic_s",   4'hE, 1'b1, 32'hFF, 32'h0F, 32'hF0, 1'b1, 4'b0011, 2, 0);
      do_op("mvn_s",   4'hF, 1'b1, 32'h55, 32'h0, 32'hFFFF_FFFF, 1'b1, 4'b1011, 2, 0);
`ifdef ALU_SEQ_CARRY_OPS_EN
      do_op("adc_s",   4'h5, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 4'b0110, 3, 0);
      do_op("tst",     4'h8, 1'b0, 32'hF0, 32'h0F, 32'h0, 1'b0, 4'b0110, 2, 0);
      do_op("mov_ns",  4'hD, 1'b0, 32'h0, 32'h1234, 32'h1234, 1'b1, 4'b0110, 2, 0);
      do_op("eor_bp",  4'h1, 1'b1, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b1, 4'b0010, 2, 10);
`else
      do_op("adc_s",   4'h5, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1, 4'b1000, 3, 0);
      do_op("tst",     4'h8, 1'b0, 32'hF0, 32'h0F, 32'h0, 1'b0, 4'b0100, 2, 0);
      do_op("mov_ns",  4'hD, 1'b0, 32'h0, 32'h1234, 32'h1234, 1'b1, 4'b0100, 2, 0);
      do_op("eor_bp",  4'h1, 1'b1, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b1, 4'b0000, 2, 10);
`endif

      // Abort an ADD S=1 while it sits in its first pass.
      req_opcode = 4'h4;
      req_s      = 1'b1;
      req_a      = 32'h7FFF_FFFF;
      req_b      = 32'h1;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("abort.in_pass1", {31'b0, req_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort.flags", {28'b0, flags}, 32'd0);
      check("abort.req_ready", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("abort.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_rst", 4'hD, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Multi-pass sequencer that drives the combinational `alu` from the ARM data-processing side. It accepts one ARM DP opcode at a time on a valid/ready request port and maps it to one or two ALU control codes, issued on successive cycles. It assembles the result and ARM NZCV flags, then returns them on a valid/ready response port. It sits between decode/register-read and writeback, and owns the architectural NZCV register.

## Interface
- `BITS`, 32, datapath width; matches `alu` BITS
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in 1: request valid
- `req_ready` out 1: sequencer idle, can accept
- `req_opcode` in 4: ARM DP opcode
- `req_s` in 1: S bit (set flags)
- `req_a`, `req_b` in BITS: operands Rn, Op2
- `alu_a`, `alu_b` out BITS: ALU operands (registered)
- `alu_control` out 4: ALU control code (registered)
- `alu_c` in BITS: ALU result
- `alu_ovfl` in 1: ALU overflow/carry flag
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response accepted
- `rsp_result` out BITS: final result
- `rsp_wb` out 1: write result to Rd (0 for TST/TEQ/CMP/CMN)
- `flags` out 4: NZCV register, N=bit3

## Operation
- States: IDLE, PASS1, PASS2, RESP. `req_ready` = (state==IDLE).
- IDLE: on `req_valid&&req_ready`, latch opcode/S/operands; load pass-1 `alu_*`; go to PASS1.
- PASS1: capture `alu_c` as t and `alu_ovfl` as o1. Go to PASS2 if the op needs it; otherwise go to RESP.
- PASS2: capture r and o2; go to RESP.
- RESP: `rsp_valid`=1 and outputs held stable until `rsp_ready`; then go to IDLE.
- Pass-1 mapping (ALU codes: 0000 add-s, 0001 sub-s, 0010 add-u, 0011 sub-u, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR):
  - AND/TST: 0100 (a,b)
  - EOR/TEQ: 0110 (a,b)
  - ORR: 0101 (a,b)
  - BIC: 0100 (a,~b)
  - MOV: 0101 (0,b)
  - MVN: 0111 (b,b)
  - ADD/CMN: 0000 (a,b)
  - SUB/CMP: 0001 (a,b)
  - RSB: 0001 (b,a)
- Arithmetic ops take a second pass when flags are set (S=1, or any CMP/CMN). Pass 2 uses the same operands with the unsigned code (0010 or 0011). Without flags they take one pass.
- Flag rules:
  - Logic ops: N=r[BITS-1], Z=(r==0); C and V unchanged.
  - ADD/CMN: N and Z from the pass-1 result; V=o1; C=o2.
  - SUB/RSB/CMP: N and Z from the pass-1 result; V=o1; C=~o2 (ARM not-borrow).
  - The ALU `zero`/`neg` outputs are unused; N and Z are always computed locally from the captured result.
- Flags are written only when S=1 or the opcode is TST/TEQ/CMP/CMN. They update on the edge entering RESP.
- `rsp_result` holds the pass-1 result for all non-carry ops.
- Carry ops (ADC/SBC/RSC): see Configuration.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_wb`=0, `flags`=0000, `alu_a`=`alu_b`=0, `alu_control`=0000.
- Latency from the accept edge to `rsp_valid`: one-pass op, 2 cycles; two-pass op, 3 cycles.
- Throughput is one op per (passes+2) cycles when `rsp_ready`=1. There is no overlap: `req_ready`=0 from PASS1 through RESP.
- `rsp_ready` held low stalls in RESP indefinitely; result and flags are stable throughout the stall.
- Reset asserted mid-operation aborts the op. No response is produced, flags are cleared, and the sequencer is in IDLE on `rst_n` release.
- The flag value read for carry-in is sampled at the accept edge.

## Configuration
- `ALU_SEQ_CARRY_OPS_EN` defined: ADC/SBC/RSC always take two passes.
  - Pass 1: ADC 0010 (a,b); SBC 0011 (a,b); RSC 0011 (b,a).
  - Pass 2: same code on (t, k), where k = {0…,C} for ADC and {0…,~C} for SBC/RSC.
  - Result is the pass-2 result r. N and Z are computed from r.
  - C: ADC gives o1|o2; SBC/RSC give ~(o1|o2).
  - V: ADC gives (a[m]==b[m])&&(r[m]!=a[m]); SBC gives (a[m]!=b[m])&&(r[m]!=a[m]); RSC uses the same SBC formula with a and b swapped. Here m=BITS-1.
- Macro undefined: ADC, SBC and RSC execute exactly as ADD, SUB and RSB, and the carry flag is ignored.

## Test plan
- ADD S=1, a=0x7FFFFFFF, b=1: `rsp_result`=0x80000000, flags=1001, `rsp_wb`=1, `rsp_valid` 3 cycles after accept.
- CMP, a=b=5: `rsp_wb`=0, flags=0110. SUB S=0, a=3, b=5: result 0xFFFFFFFE, flags unchanged, latency 2.
- BIC a=0xFF, b=0x0F, S=1 with prior flags 0011: result 0xF0, flags 0011. MVN b=0: result 0xFFFFFFFF, flags 1011.
- Macro on, C=1, ADC S=1, a=0xFFFFFFFF, b=0: result 0, flags 0110. Macro off, same stimulus: result 0xFFFFFFFF, flags 1000.
- Backpressure: hold `rsp_ready`=0 for 10 cycles. `rsp_valid`, result and flags stay stable and `req_ready` stays 0; one cycle after `rsp_ready`=1, `req_ready`=1.
- Assert `rst_n`=0 during PASS1 of ADD S=1: no `rsp_valid`, flags=0000; a new request is accepted on the first cycle after release.
